// File: rtl/ysyx_25040109_core_ctrl.sv
// Multi-cycle core controller: sequences fetch, decode, memory and write-back, and owns PC/IR.
// Optional performance counters are enabled by defining YSYX_25040109_PERF_COUNTER_EN.
module ysyx_25040109_core_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_inst,
  output logic [31:0] inst,
  input  logic        inst_invalid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_ecall,
  input  logic        reg_write_en_idu,
  input  logic [4:0]  rd_addr,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_valid,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic        rf_wen,
  output logic        halt,
  output logic [2:0]  state,
  output logic [63:0] perf_cycles,
  output logic [63:0] perf_instret
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (ifu_valid) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        if (inst_invalid)              state_d = S_HALT;
        else if (is_load || is_store)  state_d = S_MEM;
        else if (is_ecall)             state_d = S_WB;  // trap target arrives through pc_next
        else                           state_d = S_WB;
      end
      S_MEM: begin
        if (lsu_valid) state_d = S_WB;
        else           state_d = S_MEM;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // IR captures only on the fetch handshake; PC only advances on leaving write-back.
  always_comb begin
    inst_d = inst_q;
    pc_d   = pc_q;
    if (state_q == S_FETCH && ifu_valid) inst_d = ifu_inst;
    else                                 inst_d = inst_q;
    if (state_q == S_WB) pc_d = pc_next;
    else                 pc_d = pc_q;
  end

  always_comb begin
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    lsu_wen = 1'b0;
    rf_wen  = 1'b0;
    halt    = 1'b0;
    case (state_q)
      S_FETCH: ifu_req = 1'b1;
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_wen = is_store;
      end
      S_WB:    rf_wen = reg_write_en_idu & (rd_addr != 5'd0) & ~is_store;
      S_HALT:  halt = 1'b1;
      default: ifu_req = 1'b0;
    endcase
  end

  assign state = state_q;
  assign pc    = pc_q;
  assign inst  = inst_q;

`ifdef YSYX_25040109_PERF_COUNTER_EN
  logic [63:0] cycles_q, cycles_d;
  logic [63:0] instret_q, instret_d;

  always_comb begin
    if (state_q != S_HALT) cycles_d = cycles_q + 64'd1;
    else                   cycles_d = cycles_q;
    if (state_q == S_WB) instret_d = instret_q + 64'd1;
    else                 instret_d = instret_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q  <= 64'h0;
      instret_q <= 64'h0;
    end else begin
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
    end
  end

  assign perf_cycles  = cycles_q;
  assign perf_instret = instret_q;
`else
  assign perf_cycles  = 64'h0;
  assign perf_instret = 64'h0;
`endif

endmodule

// File: doc/ysyx_25040109_core_ctrl.md
YSYX_25040109_CORE_CTRL -- requirements
Module: ysyx_25040109_core_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h8000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: ifu_req  output  1  fetch request; ifu_valid  input  1  fetch done; ifu_inst  input  32  fetched word.
REQ-005 SHALL have port: inst  output  32  instruction register, drives decoder inst input.
REQ-006 SHALL have decoder-return inputs, 1 bit each unless stated: inst_invalid, is_load, is_store, is_ecall, reg_write_en_idu, rd_addr (5).
REQ-007 SHALL have ports: lsu_req  output  1  memory request; lsu_wen  output  1  store (1) / load (0); lsu_valid  input  1  memory done.
REQ-008 SHALL have ports: pc_next  input  32  next PC from execute; pc  output  32  current PC.
REQ-009 SHALL have ports: rf_wen  output  1  register-file write strobe; halt  output  1  core stopped; state  output  3  debug state code.
REQ-010 SHALL have ports: perf_cycles  output  64, perf_instret  output  64  performance counters.

Function
REQ-011 SHALL implement Moore FSM, codes: IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4, HALT=5; state output = current code.
REQ-012 IDLE: all strobes 0; next state FETCH unconditionally.
REQ-013 FETCH: ifu_req=1, held until ifu_valid=1; on that edge inst<=ifu_inst, next DECODE; ifu_valid may arrive in first FETCH cycle.
REQ-014 DECODE: exactly one cycle; inst_invalid=1 -> HALT; else is_load|is_store -> MEM; else -> WB; is_ecall takes WB path (trap PC supplied via pc_next).
REQ-015 MEM: lsu_req=1, lsu_wen=is_store, both held stable until lsu_valid=1; then WB.
REQ-016 WB: exactly one cycle; rf_wen = reg_write_en_idu & (rd_addr!=0) & ~is_store; pc<=pc_next at end of cycle; next FETCH.
REQ-017 HALT: halt=1, all strobes 0, pc/inst frozen; exit only by reset.
REQ-018 ifu_valid outside FETCH and lsu_valid outside MEM SHALL be ignored.
REQ-019 All strobes (ifu_req, lsu_req, lsu_wen, rf_wen, halt) SHALL decode from state register only, no input-to-output combinational path except lsu_wen/rf_wen from decoder inputs.
REQ-020 Latency: non-memory instruction with zero-wait fetch = 3 cycles FETCH->next FETCH; memory instruction with zero-wait fetch/LSU = 4 cycles.
REQ-021 inst SHALL change only on FETCH handshake edge; pc only in WB.

Reset
REQ-022 rst assertion SHALL immediately force state=IDLE, pc=RESET_PC, inst=32'h0, perf counters=0, halt=0, all strobes 0.
REQ-023 Reset mid-handshake (FETCH/MEM) SHALL abandon request; no inst/pc update from the aborted transaction.
REQ-024 First FETCH SHALL occur second rising edge after rst deassertion (IDLE occupies one cycle).

Configuration
REQ-025 Macro YSYX_25040109_PERF_COUNTER_EN defined: perf_cycles increments every non-reset cycle except in HALT; perf_instret increments on each WB cycle; both wrap modulo 2^64.
REQ-026 Macro undefined: counters not instantiated; perf_cycles and perf_instret tied to 64'h0.

Verification
REQ-027 Reset release, ifu_valid tied 1, ifu_inst=32'h00100093 (addi x1,x0,1), pc_next=pc+4 -> ifu_req cycle 1, DECODE cycle 2, rf_wen=1 in WB cycle 3, pc=32'h8000_0004 after.
REQ-028 Load (is_load=1, rd_addr=5) with lsu_valid delayed 3 cycles -> lsu_req=1, lsu_wen=0 held 4 cycles, then WB rf_wen=1, instret+1.
REQ-029 Store (is_store=1, reg_write_en_idu=0) -> lsu_wen=1 in MEM, rf_wen=0 in WB, pc advances.
REQ-030 inst_invalid=1 in DECODE -> state=5, halt=1 permanently, ifu_req stays 0 for 20 cycles, perf_cycles frozen (macro on).
REQ-031 rst pulsed while in MEM with lsu_req=1 -> lsu_req drops same cycle, pc=32'h8000_0000, state=0, late lsu_valid ignored.
REQ-032 addi with rd_addr=0 -> rf_wen=0 in WB; ifu_valid pulsed during DECODE -> inst unchanged.
